// File: rtl/adc_tx_pkg.sv
// Shared state encoding, sync byte and small helpers for the ADC-to-TX sequencer.
package adc_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_HDR      = 3'd1,
    S_CONV     = 3'd2,
    S_WAIT_EOC = 3'd3,
    S_SEND     = 3'd4,
    S_WAIT_EOT = 3'd5,
    S_NEXT     = 3'd6,
    S_WAIT_PER = 3'd7
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  function automatic int chw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Byte select with constant part-selects only, so the index width never matters.
  function automatic logic [7:0] pick_byte(input logic [63:0] d, input int idx);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (i == idx) b = d[8*i +: 8];
    end
    return b;
  endfunction

endpackage

// File: rtl/adc_tx_timer.sv
// Loadable down-counter with enable; stops at zero and flags it.
module adc_tx_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_r;

  // load has priority over decrement; the count saturates at zero
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_r <= W'(0);
    end else if (load_i) begin
      cnt_r <= val_i;
    end else if (en_i && (cnt_r != W'(0))) begin
      cnt_r <= cnt_r - W'(1);
    end
  end

  assign zero_o = (cnt_r == W'(0));

endmodule

// File: rtl/adc_tx_seq.sv
// Multi-channel ADC scan sequencer streaming samples MSB-byte-first to a byte TX.
// Define ADC_TX_HEADER_EN to prefix every frame with the sync byte.
module adc_tx_seq
  import adc_tx_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int DW     = 12,
  parameter int BYTES  = 2,
  parameter int TO_CYC = 1000,
  parameter int PW     = 24
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   sts_i,
  input  logic                   stop_i,
  input  logic                   mode_i,
  input  logic [PW-1:0]          period_i,
  input  logic                   eoc_i,
  input  logic [DW-1:0]          adc_data_i,
  input  logic                   eot_i,
  output logic [chw(NCH)-1:0]    ch_o,
  output logic                   strc_o,
  output logic [7:0]             tx_data_o,
  output logic                   st_o,
  output logic                   eos_o,
  output logic                   frame_done_o,
  output logic                   err_o
);

  localparam int CHW = chw(NCH);
  localparam int DBW = BYTES * 8;
  localparam int TW  = $clog2(TO_CYC + 1);
  localparam int BIW = (BYTES > 1) ? $clog2(BYTES) : 1;

`ifdef ADC_TX_HEADER_EN
  localparam state_e FIRST_ST = S_HDR;
`else
  localparam state_e FIRST_ST = S_CONV;
`endif

  state_e          state_r;
  logic            mode_r;
  logic            stop_r;
  logic            hdr_r;
  logic [DBW-1:0]  data_r;
  logic [BIW-1:0]  byte_idx_r;
  logic            to_load_s, to_en_s, to_zero_s;
  logic            per_load_s, per_en_s, per_zero_s;
  logic [PW-1:0]   per_val_s;

  // A zero period still idles for one cycle between frames
  always_comb begin
    if (period_i == PW'(0)) begin
      per_val_s = PW'(1);
    end else begin
      per_val_s = period_i;
    end
  end

  assign to_load_s  = (state_r == S_CONV);
  assign to_en_s    = (state_r == S_WAIT_EOC);
  // Reloaded while the last byte drains so WAIT_PER lasts exactly the period
  assign per_load_s = (state_r == S_WAIT_EOT);
  assign per_en_s   = (state_r == S_NEXT) || (state_r == S_WAIT_PER);

  adc_tx_timer #(.W(TW)) u_to_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (to_load_s),
    .en_i   (to_en_s),
    .val_i  (TW'(TO_CYC)),
    .zero_o (to_zero_s)
  );

  adc_tx_timer #(.W(PW)) u_per_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (per_load_s),
    .en_i   (per_en_s),
    .val_i  (per_val_s),
    .zero_o (per_zero_s)
  );

  // Sequencer FSM with registered strobes and data outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r      <= S_IDLE;
      mode_r       <= 1'b0;
      stop_r       <= 1'b0;
      hdr_r        <= 1'b0;
      data_r       <= {DBW{1'b0}};
      byte_idx_r   <= BIW'(0);
      ch_o         <= CHW'(0);
      strc_o       <= 1'b0;
      st_o         <= 1'b0;
      tx_data_o    <= 8'h00;
      eos_o        <= 1'b1;
      frame_done_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      strc_o       <= 1'b0;
      st_o         <= 1'b0;
      frame_done_o <= 1'b0;
      if ((state_r != S_IDLE) && stop_i) begin
        stop_r <= 1'b1;
      end
      case (state_r)
        S_IDLE: begin
          if (sts_i) begin
            mode_r  <= mode_i;
            stop_r  <= 1'b0;
            err_o   <= 1'b0;
            ch_o    <= CHW'(0);
            eos_o   <= 1'b0;
            state_r <= FIRST_ST;
          end
        end
        S_HDR: begin
          st_o      <= 1'b1;
          tx_data_o <= SYNC_BYTE;
          hdr_r     <= 1'b1;
          state_r   <= S_WAIT_EOT;
        end
        S_CONV: begin
          strc_o  <= 1'b1;
          state_r <= S_WAIT_EOC;
        end
        S_WAIT_EOC: begin
          // a conversion landing on the expiry cycle still counts as good data
          if (eoc_i) begin
            data_r     <= DBW'(adc_data_i);
            byte_idx_r <= BIW'(BYTES - 1);
            state_r    <= S_SEND;
          end else if (to_zero_s) begin
            data_r     <= {DBW{1'b1}};
            byte_idx_r <= BIW'(BYTES - 1);
            err_o      <= 1'b1;
            state_r    <= S_SEND;
          end
        end
        S_SEND: begin
          st_o      <= 1'b1;
          tx_data_o <= pick_byte(64'(data_r), int'(byte_idx_r));
          state_r   <= S_WAIT_EOT;
        end
        S_WAIT_EOT: begin
          if (eot_i) begin
            if (hdr_r) begin
              hdr_r   <= 1'b0;
              state_r <= S_CONV;
            end else if (byte_idx_r == BIW'(0)) begin
              state_r <= S_NEXT;
            end else begin
              byte_idx_r <= byte_idx_r - BIW'(1);
              state_r    <= S_SEND;
            end
          end
        end
        S_NEXT: begin
          if (ch_o != CHW'(NCH - 1)) begin
            ch_o    <= ch_o + CHW'(1);
            state_r <= S_CONV;
          end else begin
            frame_done_o <= 1'b1;
            ch_o         <= CHW'(0);
            if (mode_r && !stop_r) begin
              state_r <= S_WAIT_PER;
            end else begin
              eos_o   <= 1'b1;
              state_r <= S_IDLE;
            end
          end
        end
        S_WAIT_PER: begin
          if (stop_r) begin
            eos_o   <= 1'b1;
            state_r <= S_IDLE;
          end else if (per_zero_s) begin
            state_r <= FIRST_ST;
          end
        end
        default: begin
          eos_o   <= 1'b1;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
